// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, response
// error codes, FSM state type and the funct3 legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_t;

    // Unsigned variants exist only for loads.
    function automatic logic f3_is_legal(input logic store, input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW: return 1'b1;
            F3_LBU, F3_LHU:      return !store;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into a read word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_funct3,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_funct3)
            F3_LB:   o_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_load = {{(DATA_W-8){1'b0}}, w_byte};
            F3_LH:   o_load = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_LHU:  o_load = {{(DATA_W-16){1'b0}}, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves o_merged unassigned (no latch).
        o_merged = i_word;
        case (i_funct3[1:0])
            2'b00:   o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            2'b01:   o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns core load/store requests into word-aligned
// read, write or read-modify-write cycles, and reports request errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        r_state;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic [1:0]        w_err;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign w_accept = req_valid && req_ready;

    // First matching error wins: illegal funct3, then range, then alignment.
    always_comb begin
        w_err = ERR_NONE;
        if (!f3_is_legal(req_store, req_funct3))
            w_err = ERR_ILLEGAL;
        else if ((req_addr >> ADDR_BITS) != '0)
            w_err = ERR_RANGE;
        else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            w_err = ERR_MISALIGN;
    end

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .i_word    (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr_lo  <= '0;
            r_funct3   <= '0;
            r_wdata    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_NONE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_addr_lo <= req_addr[1:0];
                    r_funct3  <= req_funct3;
                    r_wdata   <= req_wdata;
                    req_ready <= 1'b0;
                    if (w_err != ERR_NONE) begin
                        resp_valid <= 1'b1;
                        resp_err   <= w_err;
                        r_state    <= ST_RESP;
                    end else begin
                        mem_addr <= {req_addr[31:2], 2'b00};
                        if (!req_store) begin
                            mem_read <= 1'b1;
                            r_state  <= ST_RD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                            r_state   <= ST_WR;
                        end else begin
                            mem_read <= 1'b1;
                            r_state  <= ST_RMW_RD;
                        end
                    end
                end
                ST_RD: begin
                    mem_read   <= 1'b0;
                    mem_addr   <= '0;
                    resp_rdata <= w_load;
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_WR, ST_RMW_WR: begin
                    mem_write  <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                // mem_addr is left untouched so it stays stable into the write half.
                ST_RMW_RD: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_wdata <= w_merged;
                    r_state   <= ST_RMW_WR;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= ERR_NONE;
                    req_ready  <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic compared against a byte-addressed reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    load_store_unit #(.ADDR_BITS(12), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-organised data memory seen by the DUT.
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

    always @(negedge clk) if (mem_read && mem_write) overlap_cnt++;

    // Reference model: little-endian byte array, updated per request.
    logic [7:0] ref_bytes [0:4095];

    function automatic logic [31:0] ref_word(input int byte_addr);
        int wa;
        wa = byte_addr - (byte_addr % 4);
        return {ref_bytes[wa+3], ref_bytes[wa+2], ref_bytes[wa+1], ref_bytes[wa]};
    endfunction

    task automatic ref_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic [1:0] err, output int lat,
                              output bit reads, output int writes);
        int size;
        longint v;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        rd = '0; lat = 1; reads = 0; writes = 0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (st && f3[2]))
            err = 2'b11;
        else if (a >= 32'h1000)
            err = 2'b10;
        else if ((int'(a[1:0]) % size) != 0)
            err = 2'b01;
        else
            err = 2'b00;
        if (err == 2'b00) begin
            if (st) begin
                for (int i = 0; i < size; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
                lat    = (size == 4) ? 2 : 3;
                reads  = (size != 4);
                writes = 1;
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (longint'(ref_bytes[int'(a) + i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'sd1 <<< (8*size));
                rd    = v[31:0];
                lat   = 2;
                reads = 1;
            end
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        bit          saw_rd;
        int          n_wr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        bit          proto_bad;
        bit          timeout;
    } result_t;

    // Issue one request and observe the DUT until its response pulse.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output result_t r);
        int  guard;
        bit  done;
        r = '{rdata: '0, err: '0, lat: 0, saw_rd: 0, n_wr: 0, wr_addr: '0,
              wr_data: '0, proto_bad: 0, timeout: 0};
        done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) r.timeout = 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r.lat = 1;
        for (int c = 0; c < 10; c++) begin
            if (mem_read) r.saw_rd = 1;
            if (mem_write) begin
                r.n_wr++;
                r.wr_addr = mem_addr;
                r.wr_data = mem_wdata;
            end
            if (mem_read || mem_write) begin
                if (mem_addr !== {a[31:2], 2'b00}) r.proto_bad = 1;
            end else if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                r.proto_bad = 1;
            end
            if (req_ready !== 1'b0) r.proto_bad = 1;
            if (resp_valid === 1'b1) begin
                r.rdata = resp_rdata;
                r.err   = resp_err;
                done    = 1;
                break;
            end
            @(posedge clk); #1;
            r.lat++;
        end
        if (!done) r.timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b rd=%h err=%b mr=%b mw=%b ma=%h md=%h expected all 0",
                     resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        result_t     r;
        logic [31:0] e_rd;
        logic [1:0]  e_err;
        int          e_lat, e_wr;
        bit          e_rds;
        logic [2:0]  f3s [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4]  = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] exp [4]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};

        ref_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, e_rd, e_err, e_lat, e_rds, e_wr);
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r);
        checks++;
        if (r.timeout || r.err !== 2'b00 || r.lat != 2 || r.saw_rd) begin
            errors++;
            $display("FAIL sw_resp: got err=%b lat=%0d rd_seen=%0b to=%0b expected err=00 lat=2 rd_seen=0",
                     r.err, r.lat, r.saw_rd, r.timeout);
        end
        checks++;
        if (r.n_wr != 1 || r.wr_addr !== 32'h10 || r.wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_write: got n=%0d addr=%h data=%h expected n=1 addr=00000010 data=deadbeef",
                     r.n_wr, r.wr_addr, r.wr_data);
        end
        for (int i = 0; i < 4; i++) begin
            ref_access(1'b0, f3s[i], adr[i], 32'h0, e_rd, e_err, e_lat, e_rds, e_wr);
            do_req(1'b0, f3s[i], adr[i], 32'h0, r);
            checks++;
            if (r.timeout || r.rdata !== exp[i] || r.err !== 2'b00 || r.lat != 2 || r.n_wr != 0) begin
                errors++;
                $display("FAIL load_ext[%0d]: got data=%h err=%b lat=%0d wr=%0d expected data=%h err=00 lat=2 wr=0",
                         i, r.rdata, r.err, r.lat, r.n_wr, exp[i]);
            end
        end
    endtask

    task automatic test_rmw();
        result_t     r;
        logic [31:0] e_rd;
        logic [1:0]  e_err;
        int          e_lat, e_wr;
        bit          e_rds;
        ref_access(1'b1, 3'b000, 32'h11, 32'h000000AA, e_rd, e_err, e_lat, e_rds, e_wr);
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, r);
        checks++;
        if (r.timeout || r.err !== 2'b00 || r.lat != 3 || !r.saw_rd || r.rdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_resp: got err=%b lat=%0d rd_seen=%0b data=%h expected err=00 lat=3 rd_seen=1 data=0",
                     r.err, r.lat, r.saw_rd, r.rdata);
        end
        checks++;
        if (r.n_wr != 1 || r.wr_addr !== 32'h10 || r.wr_data !== 32'hDEADAAEF || r.proto_bad) begin
            errors++;
            $display("FAIL sb_write: got n=%0d addr=%h data=%h proto=%0b expected n=1 addr=00000010 data=deadaaef proto=0",
                     r.n_wr, r.wr_addr, r.wr_data, r.proto_bad);
        end
        ref_access(1'b0, 3'b010, 32'h10, 32'h0, e_rd, e_err, e_lat, e_rds, e_wr);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
        checks++;
        if (r.timeout || r.rdata !== 32'hDEADAAEF || r.lat != 2) begin
            errors++;
            $display("FAIL lw_after_sb: got data=%h lat=%0d expected data=deadaaef lat=2", r.rdata, r.lat);
        end
    endtask

    task automatic test_errors();
        result_t     r;
        bit          sts [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3s [7] = '{3'b010, 3'b010, 3'b011, 3'b100, 3'b001, 3'b111, 3'b010};
        logic [31:0] adr [7] = '{32'h12, 32'h1000, 32'h10, 32'h10, 32'h11, 32'h1001, 32'h1002};
        logic [1:0]  exp [7] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 7; i++) begin
            do_req(sts[i], f3s[i], adr[i], 32'h12345678, r);
            checks++;
            if (r.timeout || r.err !== exp[i] || r.lat != 1 || r.saw_rd || r.n_wr != 0 || r.rdata !== 32'h0) begin
                errors++;
                $display("FAIL err_case[%0d]: got err=%b lat=%0d rd=%0b wr=%0d data=%h expected err=%b lat=1 no mem access data=0",
                         i, r.err, r.lat, r.saw_rd, r.n_wr, r.rdata, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd, e_rd, e_dummy;
        logic [1:0]  e_err;
        int          e_lat, e_wr, guard;
        bit          e_rds;
        bit          exp_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit          exp_rv  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        wd = $urandom;
        ref_access(1'b1, 3'b010, 32'h40, wd, e_dummy, e_err, e_lat, e_rds, e_wr);
        ref_access(1'b0, 3'b010, 32'h40, 32'h0, e_rd, e_err, e_lat, e_rds, e_wr);
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = wd;
        @(posedge clk); #1;
        req_store = 1'b0; req_wdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (req_ready !== exp_rdy[i] || resp_valid !== exp_rv[i]) begin
                errors++;
                $display("FAIL b2b_cycle[%0d]: got ready=%b resp=%b expected ready=%b resp=%b",
                         i, req_ready, resp_valid, exp_rdy[i], exp_rv[i]);
            end
            if (i == 4) begin
                checks++;
                if (resp_rdata !== e_rd || resp_err !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_load_data: got %h err=%b expected %h err=00", resp_rdata, resp_err, e_rd);
                end
            end
            if (i == 3) req_valid = 1'b0;
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] snap, e_rd;
        logic [1:0]  e_err;
        int          e_lat, e_wr, guard;
        bit          e_rds, bad;
        result_t     r;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL rst_pre_rmw_rd: got mem_read=%b addr=%h expected 1 00000020", mem_read, mem_addr);
        end
        snap  = mem[8];
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== '0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got mr=%b mw=%b ma=%h md=%h ready=%b rv=%b expected zeros ready=1 rv=0",
                     mem_read, mem_write, mem_addr, mem_wdata, req_ready, resp_valid);
        end
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid || mem_write || mem_read) bad = 1;
        end
        checks++;
        if (bad || mem[8] !== snap) begin
            errors++;
            $display("FAIL rst_no_effect: got activity=%0b word=%h expected activity=0 word=%h", bad, mem[8], snap);
        end
        ref_access(1'b0, 3'b100, 32'h20, 32'h0, e_rd, e_err, e_lat, e_rds, e_wr);
        do_req(1'b0, 3'b100, 32'h20, 32'h0, r);
        checks++;
        if (r.timeout || r.rdata !== e_rd || r.err !== 2'b00) begin
            errors++;
            $display("FAIL rst_recover_load: got %h err=%b expected %h err=00", r.rdata, r.err, e_rd);
        end
    endtask

    task automatic test_random();
        result_t     r;
        logic [31:0] a, wd, e_rd;
        logic [2:0]  f3;
        logic [1:0]  e_err;
        int          e_lat, e_wr, sel;
        bit          st, e_rds;
        for (int n = 0; n < 80; n++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = $urandom_range(0, 255);
            else if (sel < 9) a = $urandom_range(0, 4095);
            else              a = $urandom;
            wd = $urandom;
            ref_access(st, f3, a, wd, e_rd, e_err, e_lat, e_rds, e_wr);
            do_req(st, f3, a, wd, r);
            checks++;
            if (r.timeout || r.err !== e_err || r.rdata !== e_rd) begin
                errors++;
                $display("FAIL rand_resp[%0d] st=%0b f3=%b a=%h: got data=%h err=%b to=%0b expected data=%h err=%b",
                         n, st, f3, a, r.rdata, r.err, r.timeout, e_rd, e_err);
            end
            checks++;
            if (r.lat != e_lat || r.saw_rd != e_rds || r.n_wr != e_wr || r.proto_bad) begin
                errors++;
                $display("FAIL rand_proto[%0d]: got lat=%0d rd=%0b wr=%0d bad=%0b expected lat=%0d rd=%0b wr=%0d bad=0",
                         n, r.lat, r.saw_rd, r.n_wr, r.proto_bad, e_lat, e_rds, e_wr);
            end
            if (e_wr == 1) begin
                checks++;
                if (r.wr_data !== ref_word(int'(a))) begin
                    errors++;
                    $display("FAIL rand_wdata[%0d]: got %h expected %h", n, r.wr_data, ref_word(int'(a)));
                end
            end
        end
    endtask

    task automatic test_final();
        int bad_words;
        bad_words = 0;
        for (int w = 0; w < 1024; w++) if (mem[w] !== ref_word(4*w)) bad_words++;
        checks++;
        if (bad_words != 0) begin
            errors++;
            $display("FAIL mem_consistency: got %0d differing words expected 0", bad_words);
        end
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlap_cnt);
        end
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) begin
            mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = mem[w][8*b +: 8];
        end
        test_reset();
        test_store_load();
        test_rmw();
        test_errors();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the core's MEM stage and the word-organised data memory.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned mem_read/mem_write cycles.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Flags misaligned, out-of-range and illegal requests without touching memory.

Parameters:
- ADDR_BITS, 12: byte-address bits backed by memory; upper bits must be zero.
- DATA_W, 32: data word width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core request strobe
- req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
- req_store  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors
- resp_err  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
- mem_read  output  1  to memory read enable
- mem_write  output  1  to memory write enable, sampled by memory on posedge
- mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wdata  output  32  full merged word
- mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- On acceptance, addr, funct3, store flag and wdata are registered. Inputs are ignored outside IDLE.
- Check order at acceptance (first match wins):
  - Illegal funct3 (011, 110, 111, or store with funct3 bit2=1) -> err 11.
  - req_addr[31:ADDR_BITS]!=0 -> err 10.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> err 01.
- Any error goes IDLE->RESP with mem_read and mem_write never asserted.
- FSM states:
  - IDLE
  - RD: mem_read=1; mem_rdata captured at end of cycle.
  - WR: mem_write=1, mem_wdata=req_wdata.
  - RMW_RD: mem_read=1; merged word captured.
  - RMW_WR: mem_write=1, mem_wdata=merged word.
  - RESP: resp_valid=1, then return to IDLE.
- Transitions: load IDLE->RD->RESP; SW IDLE->WR->RESP; SB/SH IDLE->RMW_RD->RMW_WR->RESP.
- Latency from acceptance cycle to resp_valid: load 2, SW 2, SB/SH 3, error 1.
- Throughput: next request accepted on the cycle after RESP.
- mem_addr is held stable for the whole access, including across RMW_RD/RMW_WR. mem_addr and mem_wdata are 0 whenever mem_read and mem_write are both low.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- Store merge:
  - Byte replaces bits [8*addr[1:0] +: 8] of the read word.
  - Half replaces [16*addr[1] +: 16]. Other bytes are preserved.
- mem_read and mem_write are never high in the same cycle.
- resp_valid has no backpressure; the core must accept it.
- Reset mid-operation: state returns to IDLE on the next edge. All mem_* outputs are 0 in the following cycle, and the aborted request produces no response. An RMW aborted in RMW_RD leaves memory untouched.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Error code constants ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL.
  - State enum lsu_state_t.
- Sub-module lsu_lane_align: combinational; inputs word, addr[1:0], funct3, wdata; outputs extended load value and merged store word. Unit-testable on its own.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF -> mem_write pulses 1 cycle at mem_addr 0x10, mem_wdata 0xDEADBEEF; resp_valid 2 cycles after acceptance, err 00.
- With word 0x10=0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD; each returned 2 cycles after acceptance.
- SB 0x11 data 0x000000AA on 0xDEADBEEF -> mem_read then mem_write at 0x10, mem_wdata 0xDEADAABE... exact expected value 0xDEADAAEF; LW 0x10 returns 0xDEADAAEF; resp 3 cycles after acceptance.
- LW 0x12 -> err 01; SW 0x1000 -> err 10; funct3 011 -> err 11. Each responds after 1 cycle, no mem_read or mem_write seen.
- reset asserted in RMW_RD of SB 0x20 -> next cycle all mem_* outputs 0, req_ready 1, no resp_valid, word 0x20 unchanged.
- Back-to-back requests held on req_valid -> req_ready low during RD/WR/RESP; second request accepted the cycle after RESP; mem_read and mem_write never high together.
